alu_functional_unit: RTL and testbench

- Integer ALU functional unit of the RisKy1 RV32IM execute stage.
- Computes RV32I arithmetic, logical, shift, compare and LUI results from two operands and an operation select.
- Result is registered: one clock of latency, with a valid flag travelling alongside.
- The multiply/divide unit is a separate block; this unit handles no M-extension ops.

---
 rtl/alu_functional_unit.sv | 147 ++++++++++++++
 tb/tb_alu_functional_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_functional_unit.sv
// -----------------------------------------------------------------------------
// alu_functional_unit
//
// Integer ALU for the RisKy1 RV32IM execute stage. It computes RV32I
// arithmetic, logical, shift, compare and LUI-pass results from two operands
// and an operation select. The result is registered, so it appears one clock
// after the operands. A valid flag is registered alongside the result. The
// unit accepts a new operation on every cycle and never stalls. It does not
// handle M-extension operations; those go to the separate mul/div block.
//
// Ports:
//   clk        in   1      system clock, rising-edge active
//   reset      in   1      synchronous, active-high reset
//   valid_in   in   1      op1/op2/sel are valid this cycle
//   op1        in   XLEN   rs1 value, or PC for AUIPC
//   op2        in   XLEN   rs2 value or immediate
//   sel        in   SEL_W  operation select (see alu_op_e)
//   result     out  XLEN   registered ALU result; holds while valid_in=0
//   valid_out  out  1      registered valid_in
//
// Optional feature, macro ALU_CMP_FLAGS_EN:
//   eq         out  1      registered op1 == op2
//   lt         out  1      registered signed(op1) < signed(op2)
//   ltu        out  1      registered unsigned(op1) < unsigned(op2)
// These flags are computed for every sel value. They follow the same
// update/hold rule as result.
// -----------------------------------------------------------------------------
module alu_functional_unit #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [SEL_W-1:0] sel,
    output logic [XLEN-1:0]  result,
    output logic             valid_out
`ifdef ALU_CMP_FLAGS_EN
    ,
    output logic             eq,
    output logic             lt,
    output logic             ltu
`endif
);

    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [SEL_W-1:0] {
        OP_ADD   = SEL_W'(0),
        OP_SUB   = SEL_W'(1),
        OP_AND   = SEL_W'(2),
        OP_OR    = SEL_W'(3),
        OP_XOR   = SEL_W'(4),
        OP_SLL   = SEL_W'(5),
        OP_SRL   = SEL_W'(6),
        OP_SRA   = SEL_W'(7),
        OP_SLT   = SEL_W'(8),
        OP_SLTU  = SEL_W'(9),
        OP_PASS2 = SEL_W'(10)
    } alu_op_e;

    // Only the low bits of op2 form the shift amount; the upper bits are
    // ignored, as RV32 shifts require.
    logic [SHAMT_W-1:0] shamt;
    logic               lt_signed;
    logic               lt_unsigned;
    logic [XLEN-1:0]    alu_res;

    logic [XLEN-1:0]    result_d, result_q;
    logic               valid_d,  valid_q;

    assign shamt       = op2[SHAMT_W-1:0];
    assign lt_signed   = $signed(op1) < $signed(op2);
    assign lt_unsigned = op1 < op2;

    always_comb begin
        // NOTE: every variable written in this block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        alu_res = '0;
        case (sel)
            OP_ADD:   alu_res = op1 + op2;
            OP_SUB:   alu_res = op1 - op2;
            OP_AND:   alu_res = op1 & op2;
            OP_OR:    alu_res = op1 | op2;
            OP_XOR:   alu_res = op1 ^ op2;
            OP_SLL:   alu_res = op1 << shamt;
            OP_SRL:   alu_res = op1 >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(op1) >>> shamt);
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_PASS2: alu_res = op2;
            default:  alu_res = '0;  // reserved encodings produce zero
        endcase
    end

    // The result holds its last value on idle cycles. valid_out simply
    // follows valid_in, so reserved ops still report valid.
    always_comb begin
        result_d = valid_in ? alu_res : result_q;
        valid_d  = valid_in;
    end

`ifdef ALU_CMP_FLAGS_EN
    logic eq_d,  eq_q;
    logic lt_d,  lt_q;
    logic ltu_d, ltu_q;

    always_comb begin
        eq_d  = valid_in ? (op1 == op2) : eq_q;
        lt_d  = valid_in ? lt_signed    : lt_q;
        ltu_d = valid_in ? lt_unsigned  : ltu_q;
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here, so every flop samples the
        // pre-edge value of its inputs regardless of statement order.
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
`ifdef ALU_CMP_FLAGS_EN
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            ltu_q    <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
`ifdef ALU_CMP_FLAGS_EN
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            ltu_q    <= ltu_d;
`endif
        end
    end

    assign result    = result_q;
    assign valid_out = valid_q;
`ifdef ALU_CMP_FLAGS_EN
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign ltu       = ltu_q;
`endif

endmodule

// File: tb/tb_alu_functional_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_functional_unit
//
// Directed-vector bench for alu_functional_unit. Each vector carries an
// expected value that was computed by hand. After the directed vectors, a
// random sweep over all sel values is compared against an independent
// reference model.
// When ALU_CMP_FLAGS_EN is defined, the bench also checks the eq/lt/ltu flags.
// -----------------------------------------------------------------------------
module tb_alu_functional_unit;

    localparam int XLEN  = 32;
    localparam int SEL_W = 4;

    logic             clk;
    logic             reset;
    logic             valid_in;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  result;
    logic             valid_out;
`ifdef ALU_CMP_FLAGS_EN
    logic             eq;
    logic             lt;
    logic             ltu;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_functional_unit #(.XLEN(XLEN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op1       (op1),
        .op2       (op2),
        .sel       (sel),
        .result    (result),
        .valid_out (valid_out)
`ifdef ALU_CMP_FLAGS_EN
        ,
        .eq        (eq),
        .lt        (lt),
        .ltu       (ltu)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] observed,
                         input logic [XLEN-1:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model. It is written with different constructs from the RTL:
    // sign-fill by masking, and signed compare by flipping the sign bit.
    function automatic logic [XLEN-1:0] ref_alu(input logic [SEL_W-1:0] s,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [4:0]      sh;
        logic [XLEN-1:0] fill;
        sh   = b[4:0];
        fill = a[XLEN-1] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (s)
            4'd0:    return a + b;
            4'd1:    return a + ~b + 32'd1;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return (a >> sh) | fill;
            4'd8:    return {31'b0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
            4'd9:    return {31'b0, a < b};
            4'd10:   return b;
            default: return 32'h0;
        endcase
    endfunction

    // Presents one valid operation, waits one edge, then checks the outputs.
    task automatic run_vec(input string tag, input logic [SEL_W-1:0] s,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] exp_res);
        valid_in = 1'b1;
        sel      = s;
        op1      = a;
        op2      = b;
        @(posedge clk);
        #1;
        check({tag, " result"}, result, exp_res);
        check({tag, " valid"}, {31'b0, valid_out}, 32'd1);
`ifdef ALU_CMP_FLAGS_EN
        check({tag, " eq"},  {31'b0, eq},  {31'b0, a == b});
        check({tag, " lt"},  {31'b0, lt},
              {31'b0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)});
        check({tag, " ltu"}, {31'b0, ltu}, {31'b0, a < b});
`endif
    endtask

    initial begin
        logic [SEL_W-1:0] rs;
        logic [XLEN-1:0]  ra;
        logic [XLEN-1:0]  rb;

        // Hold reset for two cycles while an ADD 5+7 is presented as valid.
        reset    = 1'b1;
        valid_in = 1'b1;
        sel      = 4'd0;
        op1      = 32'd5;
        op2      = 32'd7;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset result", result, 32'h0);
            check("reset valid", {31'b0, valid_out}, 32'd0);
`ifdef ALU_CMP_FLAGS_EN
            check("reset eq", {31'b0, eq}, 32'd0);
`endif
        end
        reset = 1'b0;
        run_vec("first after reset", 4'd0, 32'd5, 32'd7, 32'd12);

        // Wrap-around and subtraction.
        run_vec("add wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        run_vec("sub 0-1",  4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run_vec("sub 10-3", 4'd1, 32'd10, 32'd3, 32'd7);

        // Shifts: only op2[4:0] counts as the shift amount.
        run_vec("sll op2=0x21", 4'd5, 32'h1, 32'h21, 32'h2);
        run_vec("srl by 31",    4'd6, 32'h8000_0000, 32'd31, 32'h1);
        run_vec("sra by 4",     4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_vec("sll by 0",     4'd5, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
        run_vec("sra by 0",     4'd7, 32'h8000_0001, 32'h0, 32'h8000_0001);
        run_vec("srl by 0",     4'd6, 32'h8000_0001, 32'h40, 32'h8000_0001);

        // Compares.
        run_vec("slt -1<1",    4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_vec("sltu max<1",  4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_vec("sltu 1<max",  4'd9, 32'd1, 32'hFFFF_FFFF, 32'd1);
        run_vec("slt equal",   4'd8, 32'd5, 32'd5, 32'd0);

        // Back-to-back operations: valid_in stays high across these vectors.
        run_vec("b2b and",   4'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        run_vec("b2b or",    4'd3,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        run_vec("b2b xor",   4'd4,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        run_vec("b2b pass2", 4'd10, 32'hAAAA_AAAA, 32'h1234_5000, 32'h1234_5000);

        // Idle gap: new operands are presented but not valid, so result holds.
        valid_in = 1'b0;
        sel      = 4'd0;
        op1      = 32'd1;
        op2      = 32'd1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("gap result held", result, 32'h1234_5000);
            check("gap valid", {31'b0, valid_out}, 32'd0);
        end

        // Reserved encodings give zero and are still reported valid.
        run_vec("reserved 12", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        run_vec("reserved 15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        // Random sweep over every sel value, checked against the reference model.
        for (int i = 0; i < 96; i++) begin
            rs = SEL_W'(i % 16);
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            run_vec("sweep", rs, ra, rb, ref_alu(rs, ra, rb));
        end

        // A reset issued mid-stream clears state even with valid_in high.
        reset    = 1'b1;
        valid_in = 1'b1;
        sel      = 4'd0;
        op1      = 32'd3;
        op2      = 32'd4;
        @(posedge clk);
        #1;
        check("mid reset result", result, 32'h0);
        check("mid reset valid", {31'b0, valid_out}, 32'd0);
        reset = 1'b0;
        run_vec("after mid reset", 4'd0, 32'd3, 32'd4, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
